// File: rtl/sram_arbiter_2x_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the two-requester SRAM arbiter.
//   DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH : geometry of the 16384x32 SRAM
//   grant_id_e   : which requester owns the SRAM port in a cycle
//   sram_req_t   : one requester's access fields at default geometry
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 14;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BE_WIDTH   = DEFAULT_DATA_WIDTH / 8;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_id_e;

    typedef struct packed {
        logic                          rnw;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] wdata;
        logic [DEFAULT_BE_WIDTH-1:0]   be;
        logic                          lock;
    } sram_req_t;

endpackage

// File: rtl/sram_arbiter_2x_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2x_if
// Bundles both requester handshakes and the SRAM-side bus.
//   master : requesters plus SRAM macro (drive requests and sram_data_out)
//   slave  : the arbiter (drives acks, read valids, rdata and SRAM controls)
// ---------------------------------------------------------------------------
interface sram_arbiter_2x_if
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_a, req_b;
    logic                  lock_a, lock_b;
    logic                  rnw_a, rnw_b;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b;
    logic [DATA_WIDTH-1:0] wdata_a, wdata_b;
    logic [BE_WIDTH-1:0]   be_a, be_b;
    logic                  ack_a, ack_b;
    logic                  rdata_valid_a, rdata_valid_b;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  sram_select;
    logic                  sram_read_not_write;
    logic [ADDR_WIDTH-1:0] sram_address;
    logic [DATA_WIDTH-1:0] sram_write_data;
    logic [BE_WIDTH-1:0]   sram_write_enable;
    logic [DATA_WIDTH-1:0] sram_data_out;

    modport master (
        output req_a, req_b, lock_a, lock_b, rnw_a, rnw_b,
               addr_a, addr_b, wdata_a, wdata_b, be_a, be_b, sram_data_out,
        input  ack_a, ack_b, rdata_valid_a, rdata_valid_b, rdata,
               sram_select, sram_read_not_write, sram_address,
               sram_write_data, sram_write_enable
    );

    modport slave (
        input  req_a, req_b, lock_a, lock_b, rnw_a, rnw_b,
               addr_a, addr_b, wdata_a, wdata_b, be_a, be_b, sram_data_out,
        output ack_a, ack_b, rdata_valid_a, rdata_valid_b, rdata,
               sram_select, sram_read_not_write, sram_address,
               sram_write_data, sram_write_enable
    );

endinterface

// File: rtl/sram_arbiter_2x_rr_select.sv
// ---------------------------------------------------------------------------
// sram_arb_rr_select
// Combinational grant decision: round-robin between A and B, except that a
// locked burst owner keeps the port while under MAX_BURST consecutive grants.
//   enable            : arbitration allowed this cycle
//   req_*/lock_*      : requests and lock wishes
//   last_grant        : most recent grantee
//   burst_owner_valid : last grantee is in a locked burst
//   burst_count       : grants in the current locked burst
//   grant_valid/id    : decision
// ---------------------------------------------------------------------------
module sram_arb_rr_select
    import sram_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       enable,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       lock_a,
    input  logic       lock_b,
    input  grant_id_e  last_grant,
    input  logic       burst_owner_valid,
    input  logic [7:0] burst_count,
    output logic       grant_valid,
    output grant_id_e  grant_id
);
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    logic owner_lock;

    assign owner_lock = (last_grant == GRANT_A) ? lock_a : lock_b;

    // The burst limit only matters under contention; a lone requester always wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = GRANT_A;
        if (enable) begin
            if (req_a && req_b) begin
                grant_valid = 1'b1;
                if (burst_owner_valid && owner_lock && (burst_count < MAX_BURST_C)) begin
                    grant_id = last_grant;
                end else begin
                    grant_id = (last_grant == GRANT_A) ? GRANT_B : GRANT_A;
                end
            end else if (req_a) begin
                grant_valid = 1'b1;
                grant_id    = GRANT_A;
            end else if (req_b) begin
                grant_valid = 1'b1;
                grant_id    = GRANT_B;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter_2x.sv
// ---------------------------------------------------------------------------
// sram_arbiter_2x
// Two-requester arbiter/sequencer for a shared single-port byte-write SRAM.
//   clk         : clock (also clocks the SRAM)
//   reset_n     : asynchronous active-low reset
//   clk__enable : when low, no grant, no state change, SRAM deselected
//   bus         : requester handshakes, read return and SRAM controls
// Read data returns one cycle after the grant with a per-requester valid.
// ---------------------------------------------------------------------------
module sram_arbiter_2x
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input logic              clk,
    input logic              reset_n,
    input logic              clk__enable,
    sram_arbiter_2x_if.slave bus
);
    localparam int         BE_WIDTH    = DATA_WIDTH / 8;
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    grant_id_e             last_grant;
    logic [7:0]            burst_count;
    logic                  burst_owner_valid;
    logic                  rd_pending_a;
    logic                  rd_pending_b;

    logic                  arb_enable;
    logic                  grant_valid;
    grant_id_e             grant_id;
    logic                  grant_lock;
    logic                  grant_rnw;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic [BE_WIDTH-1:0]   grant_be;

    // Reset forces every output low, so arbitration is gated by reset_n too.
    assign arb_enable = clk__enable & reset_n;

    sram_arb_rr_select #(
        .MAX_BURST (MAX_BURST)
    ) u_rr_select (
        .enable            (arb_enable),
        .req_a             (bus.req_a),
        .req_b             (bus.req_b),
        .lock_a            (bus.lock_a),
        .lock_b            (bus.lock_b),
        .last_grant        (last_grant),
        .burst_owner_valid (burst_owner_valid),
        .burst_count       (burst_count),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id)
    );

    always_comb begin
        grant_lock  = bus.lock_a;
        grant_rnw   = bus.rnw_a;
        grant_addr  = bus.addr_a;
        grant_wdata = bus.wdata_a;
        grant_be    = bus.be_a;
        if (grant_id == GRANT_B) begin
            grant_lock  = bus.lock_b;
            grant_rnw   = bus.rnw_b;
            grant_addr  = bus.addr_b;
            grant_wdata = bus.wdata_b;
            grant_be    = bus.be_b;
        end
    end

    assign bus.ack_a = grant_valid && (grant_id == GRANT_A);
    assign bus.ack_b = grant_valid && (grant_id == GRANT_B);

    // Idle bus parks in read mode; during reset it is all zeros.
    assign bus.sram_select         = grant_valid;
    assign bus.sram_read_not_write = grant_valid ? grant_rnw : reset_n;
    assign bus.sram_address        = grant_valid ? grant_addr : '0;
    assign bus.sram_write_data     = grant_valid ? grant_wdata : '0;
    assign bus.sram_write_enable   = grant_valid ? (grant_be & {BE_WIDTH{~grant_rnw}}) : '0;

    assign bus.rdata_valid_a = rd_pending_a;
    assign bus.rdata_valid_b = rd_pending_b;
    assign bus.rdata         = reset_n ? bus.sram_data_out : '0;

    // last_grant resets to B so that A wins the first contended cycle.
    // rd_pending holds across disabled cycles because the SRAM output is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant        <= GRANT_B;
            burst_count       <= '0;
            burst_owner_valid <= 1'b0;
            rd_pending_a      <= 1'b0;
            rd_pending_b      <= 1'b0;
        end else if (clk__enable) begin
            rd_pending_a <= bus.ack_a & grant_rnw;
            rd_pending_b <= bus.ack_b & grant_rnw;
            if (grant_valid) begin
                last_grant <= grant_id;
                if (!grant_lock) begin
                    burst_owner_valid <= 1'b0;
                    burst_count       <= '0;
                end else if (burst_owner_valid && (grant_id == last_grant)) begin
                    if (burst_count < MAX_BURST_C) begin
                        burst_count <= burst_count + 8'd1;
                    end
                end else begin
                    burst_owner_valid <= 1'b1;
                    burst_count       <= 8'd1;
                end
            end
        end
    end

endmodule
